// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: control codes, FSM states, decode helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_alu_pkg;

   // 4-bit ALU control codes {a_invert, b_invert, operation[1:0]}
   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_NOR = 4'b1100;
   localparam logic [3:0] CTRL_SLT = 4'b0111;

   // Slice operation select (low two bits of the control code)
   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the six codes the ALU defines; anything else completes as an error.
   function automatic logic ctrl_is_legal(input logic [3:0] code);
      return (code == CTRL_AND) || (code == CTRL_OR)  || (code == CTRL_ADD) ||
             (code == CTRL_SUB) || (code == CTRL_NOR) || (code == CTRL_SLT);
   endfunction

   // Only ADD and SUB report signed overflow.
   function automatic logic ctrl_is_addsub(input logic [3:0] code);
      return (code == CTRL_ADD) || (code == CTRL_SUB);
   endfunction

endpackage

// File: rtl/msb_bit_alu.sv
// One-bit ALU slice with set/overflow outputs so it can also serve as the MSB slice.
// Latency: purely combinational.
// Backpressure: none; the slice has no handshake.
module msb_bit_alu
   import serial_alu_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       a_invert_i,
   input  logic       b_invert_i,
   input  logic       carry_in_i,
   input  logic       less_i,
   input  logic [1:0] operation_i,
   output logic       result_o,
   output logic       carry_out_o,
   output logic       set_o,
   output logic       overflow_o
);

   logic a_eff;
   logic b_eff;
   logic sum;

   assign a_eff = a_i ^ a_invert_i;
   assign b_eff = b_i ^ b_invert_i;
   assign sum   = a_eff ^ b_eff ^ carry_in_i;

   assign carry_out_o = (a_eff & b_eff) | (a_eff & carry_in_i) | (b_eff & carry_in_i);
   // set is the raw adder output; meaningful as the sign of A-B at the MSB
   assign set_o       = sum;
   // signed overflow at the MSB: carry into the sign bit differs from carry out
   assign overflow_o  = carry_in_i ^ carry_out_o;

   // Result multiplexer over the four slice operations
   always_comb begin
      result_o = 1'b0;
      unique case (operation_i)
         OP_AND:  result_o = a_eff & b_eff;
         OP_OR:   result_o = a_eff | b_eff;
         OP_ADD:  result_o = sum;
         OP_LESS: result_o = less_i;
         default: result_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU: one 1-bit slice reused WIDTH times, LSB first; build option SERIAL_ALU_SLT_OVF_FIX_EN.
// Latency: out_valid rises WIDTH edges after the input handshake edge; one op per WIDTH+2 cycles.
// Backpressure: holds result/flags in DONE until out_ready; in_ready is low from accept until return to IDLE.
module serial_alu_ctrl
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [3:0]       alu_ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             ctrl_err
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;

   logic               slice_res;
   logic               slice_cout;
   logic               slice_set;
   logic               slice_ovf;
   logic               slt_less;
   logic [WIDTH-1:0]   res_work;

   // Operands shift right each RUN cycle, so bit 0 is always the current bit idx.
   msb_bit_alu u_slice (
      .a_i         (a_q[0]),
      .b_i         (b_q[0]),
      .a_invert_i  (ctrl_q[3]),
      .b_invert_i  (ctrl_q[2]),
      .carry_in_i  (carry_q),
      .less_i      (1'b0),
      .operation_i (ctrl_q[1:0]),
      .result_o    (slice_res),
      .carry_out_o (slice_cout),
      .set_o       (slice_set),
      .overflow_o  (slice_ovf)
   );

`ifdef SERIAL_ALU_SLT_OVF_FIX_EN
   // True signed compare: correct the sign of A-B when the subtraction overflowed.
   assign slt_less = slice_set ^ slice_ovf;
`else
   // Raw sign of A-B, bit-compatible with the combinational ALU.
   assign slt_less = slice_set;
`endif

   // FSM next-state, datapath next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ctrl_d    = ctrl_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      result_d  = result_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      res_work  = result_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d      = src_a;
               b_d      = src_b;
               ctrl_d   = alu_ctrl;
               // b_invert doubles as the +1 of two's-complement subtraction
               carry_d  = alu_ctrl[2];
               idx_d    = '0;
               result_d = '0;
               zero_d   = 1'b1;
               ovf_d    = 1'b0;
               err_d    = 1'b0;
               state_d  = ST_RUN;
            end
         end

         ST_RUN: begin
            a_d             = a_q >> 1;
            b_d             = b_q >> 1;
            carry_d         = slice_cout;
            res_work[idx_q] = slice_res;
            if (idx_q == IDX_LAST) begin
               if (ctrl_q == CTRL_SLT) begin
                  res_work[0] = slt_less;
               end
               if (!ctrl_is_legal(ctrl_q)) begin
                  res_work = '0;
               end
               zero_d  = (res_work == '0);
               ovf_d   = ctrl_is_addsub(ctrl_q) ? slice_ovf : 1'b0;
               err_d   = !ctrl_is_legal(ctrl_q);
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + CNT_W'(1);
            end
            result_d = res_work;
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign ctrl_err = err_q;

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial ALU sequencer that time-multiplexes one 1-bit ALU slice across a WIDTH-bit operation, one bit per cycle, LSB first.
- Accepts operand/control transactions on a valid/ready input handshake and returns result and flags on a valid/ready output handshake.
- Manages the carry chain and the SLT less-feedback across cycles.
- Provides an area-minimal ALU for the single-cycle CPU's low-cost configuration.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/control valid
in_ready  output  1  controller can accept a transaction
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
alu_ctrl  input  4  {a_invert, b_invert, operation[1:0]}
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow of ADD/SUB (0 for other ops)
ctrl_err  output  1  alu_ctrl not one of the six legal codes

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, result=0, zero=1, overflow=0, ctrl_err=0.
- Reset state: IDLE. Internal carry, counter and operand shift registers are cleared.
- Reset asserted mid-operation aborts immediately and discards the operation.

Legal alu_ctrl codes:
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT.
- Any other code: accepted, then completes after the normal latency with result=0, overflow=0, ctrl_err=1.

State machine:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch src_a, src_b and alu_ctrl; set carry=b_invert; set idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, bit idx of the latched operands feeds the slice with carry_in=carry and less=0.
  - The slice result is written to result bit idx; carry <= slice carry-out.
  - When idx==WIDTH-1:
    - Capture the slice's set and overflow outputs.
    - For SLT, overwrite result bit 0 with the less value.
    - Go to DONE.
  - Otherwise idx <= idx+1.
- DONE:
  - out_valid=1; result, zero, overflow and ctrl_err are stable.
  - On out_ready: go to IDLE with out_valid=0 the next cycle.
  - in_ready stays 0 while in DONE (no overlap).

Timing and flags:
- Latency: the handshake edge is cycle 0; out_valid rises after exactly WIDTH further edges.
- Throughput: one op per WIDTH+2 cycles, assuming out_ready is held high.
- zero is computed from the final result, including the SLT bit-0 fix.
- overflow is reported only for ADD/SUB; it is forced to 0 for AND, OR, NOR and SLT.
- Carry-out beyond the MSB is discarded.
- The out_ready level is ignored outside DONE.
- in_valid is ignored outside IDLE; operands are not re-sampled.

Optional Feature:
Macro: SERIAL_ALU_SLT_OVF_FIX_EN
- Defined: SLT less = set XOR overflow, giving a correct signed compare even when A−B overflows.
- Undefined: less = set (raw MSB of A−B), matching the combinational ALU bit-for-bit.

Decomposition:
Shared package serial_alu_pkg holds:
- The 4-bit ALU control code constants: CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_NOR, CTRL_SLT.
- The state enum: ST_IDLE, ST_RUN, ST_DONE.

Sub-module:
- The existing msb_bit_alu slice, instantiated once. It is the natural sub-module because it provides set and overflow.
- Its operation input is driven from the latched alu_ctrl[1:0].
- Its a_invert/b_invert inputs are driven from alu_ctrl[3]/alu_ctrl[2].
- The controller itself is the FSM plus counter and shift registers, with no other children.

Test Plan:
- Reset: assert rst_n=0 during RUN -> in_ready=1, out_valid=0, result=0, zero=1 on the same edge; no completion follows.
- ADD overflow, WIDTH=32: A=0x7FFFFFFF, B=0x00000001, ctrl=0010 -> after 32 cycles, result=0x80000000, overflow=1, zero=0.
- SUB zero: A=B=0x12345678, ctrl=0110 -> result=0, zero=1, overflow=0; AND/OR/NOR on 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0x000F000F.
- SLT: A=0xFFFFFFFE, B=1 -> result=1. With A=0x80000000, B=1: result=0 when macro undefined, 1 when SERIAL_ALU_SLT_OVF_FIX_EN is defined.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, back-to-back op accepted.
- Illegal ctrl=1010 -> after WIDTH cycles, out_valid=1, ctrl_err=1, result=0, zero=1.
